// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS multiply/divide unit with architectural HI/LO.
// MULT/MULTU use shift-add, DIV/DIVU use restoring shift-subtract, one bit
// per cycle; MTHI/MTLO write HI/LO directly in a single cycle.
// Optional feature macro: MULDIV_MADD_EN enables MADDU/MADD (op 110/111),
// which accumulate the product into {hi,lo}. Without it those ops are ignored.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t state, state_next;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;
    logic             neg_q;
    logic             neg_r;
    logic             div_mode;
    logic             divz_r;

    logic             accept;
    logic             is_mul;
    logic             is_div;
    logic             launch;
    logic             divz_now;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ok;

    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod_signed;
    logic [2*WIDTH-1:0] mul_result;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    assign accept = start && (state == IDLE);
    assign is_div = (op[2:1] == 2'b01);
`ifdef MULDIV_MADD_EN
    assign is_mul = (op[2:1] == 2'b00) || (op[2:1] == 2'b11);
`else
    assign is_mul = (op[2:1] == 2'b00);
`endif
    assign launch   = accept && (is_mul || is_div);
    assign divz_now = is_div && (opB == '0);

    // Signed ops (op[0]=1) run on magnitudes; the sign is restored in FIX.
    assign a_neg = op[0] && opA[WIDTH-1];
    assign b_neg = op[0] && opB[WIDTH-1];
    assign a_mag = a_neg ? (~opA + 1'b1) : opA;
    assign b_mag = b_neg ? (~opB + 1'b1) : opB;

    // Multiply step: acc_hi:acc_lo holds partial product over the multiplier.
    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});

    // Divide step: acc_hi is the partial remainder, acc_lo shifts dividend out
    // and quotient bits in.
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd};
    assign div_ok    = ~div_diff[WIDTH];

    assign prod_mag    = {acc_hi, acc_lo};
    assign prod_signed = neg_q ? (~prod_mag + 1'b1) : prod_mag;
    assign quot        = neg_q ? (~acc_lo + 1'b1) : acc_lo;
    assign rem         = neg_r ? (~acc_hi + 1'b1) : acc_hi;

`ifdef MULDIV_MADD_EN
    logic madd_r;
    assign mul_result = madd_r ? ({hi, lo} + prod_signed) : prod_signed;
`else
    assign mul_result = prod_signed;
`endif

    assign busy = (state != IDLE);

    // State register; reset discards any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: divide by zero skips the iteration and goes straight to FIX.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (launch) begin
                    state_next = divz_now ? FIX : RUN;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    state_next = FIX;
                end
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, per-cycle iteration, and HI/LO writeback.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_mode <= 1'b0;
            divz_r   <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
`ifdef MULDIV_MADD_EN
            madd_r   <= 1'b0;
`endif
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && (op == 3'b100)) begin
                        hi <= opA;
                    end
                    if (accept && (op == 3'b101)) begin
                        lo <= opA;
                    end
                    if (launch) begin
                        cnt      <= '0;
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                        div_mode <= is_div;
                        divz_r   <= divz_now;
                        opnd     <= is_div ? b_mag : a_mag;
                        acc_lo   <= is_div ? a_mag : b_mag;
                        acc_hi   <= '0;
`ifdef MULDIV_MADD_EN
                        madd_r   <= op[2];
`endif
                    end
                end
                RUN: begin
                    cnt <= cnt + CW'(1);
                    if (div_mode) begin
                        acc_hi <= div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
                    end else begin
                        {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    done     <= 1'b1;
                    div_zero <= divz_r;
                    if (!divz_r) begin
                        if (div_mode) begin
                            hi <= rem;
                            lo <= quot;
                        end else begin
                            {hi, lo} <= mul_result;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed scoreboard bench for muldiv_unit (WIDTH=32).
// Expected results are computed from 64-bit reference arithmetic when each
// op is issued, queued, and compared when done pulses.
module tb_muldiv_unit;

    localparam int WIDTH = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [2:0]        op;
    logic [WIDTH-1:0]  opA;
    logic [WIDTH-1:0]  opB;
    logic              busy;
    logic              done;
    logic              div_zero;
    logic [WIDTH-1:0]  hi;
    logic [WIDTH-1:0]  lo;

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          checks    = 0;
    int          passes    = 0;
    int          lat       = 0;
    int          doneCount = 0;
    int          d0        = 0;
    logic        stableOk  = 1'b1;
    logic        busyOk    = 1'b1;
    logic [31:0] mHi       = '0;
    logic [31:0] mLo       = '0;
    exp_t        dropped;

    muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .opA      (opA),
        .opB      (opB),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock edge, then watch for done pulses and unexpected HI/LO writes.
    task automatic tick();
        @(posedge clk);
        #1;
        lat++;
        if (done === 1'b1) begin
            doneCount++;
        end else if (hi !== mHi || lo !== mLo) begin
            stableOk = 1'b0;
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t              e;
        logic signed [63:0] sa;
        logic signed [63:0] sbv;
        logic signed [63:0] sq;
        logic signed [63:0] sr;
        logic        [63:0] p;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        opA   = a;
        opB   = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        lat      = 0;
        stableOk = 1'b1;
        busyOk   = 1'b1;
        sa  = o[0] ? {{32{a[31]}}, a} : {32'b0, a};
        sbv = o[0] ? {{32{b[31]}}, b} : {32'b0, b};
        e.tag = tag;
        e.dz  = 1'b0;
        e.lat = WIDTH + 1;
        case (o)
            3'b100: begin
                mHi = a;
                checkOutput({tag, "_hi"}, {32'b0, hi}, {32'b0, mHi});
                checkOutput({tag, "_busy"}, {63'b0, busy}, 64'd0);
            end
            3'b101: begin
                mLo = a;
                checkOutput({tag, "_lo"}, {32'b0, lo}, {32'b0, mLo});
                checkOutput({tag, "_busy"}, {63'b0, busy}, 64'd0);
            end
            3'b010, 3'b011: begin
                if (b == 32'd0) begin
                    e.hi  = mHi;
                    e.lo  = mLo;
                    e.dz  = 1'b1;
                    e.lat = 1;
                end else begin
                    sq   = sa / sbv;
                    sr   = sa % sbv;
                    e.hi = sr[31:0];
                    e.lo = sq[31:0];
                end
                sb.push_back(e);
                checkOutput({tag, "_busy_on"}, {63'b0, busy}, 64'd1);
            end
            default: begin
                p = sa * sbv;
                if (o[2]) begin
                    p = p + {mHi, mLo};
                end
                e.hi = p[63:32];
                e.lo = p[31:0];
                sb.push_back(e);
                checkOutput({tag, "_busy_on"}, {63'b0, busy}, 64'd1);
            end
        endcase
    endtask

    // Wait (bounded) for done, then compare against the oldest queued result.
    task automatic awaitResult(input string tag);
        exp_t e;
        while (done !== 1'b1 && lat < 100) begin
            tick();
            if (done !== 1'b1 && busy !== 1'b1) begin
                busyOk = 1'b0;
            end
        end
        checkOutput({tag, "_done"}, {63'b0, done}, 64'd1);
        checkOutput({tag, "_sbsize"}, 64'(sb.size()), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput({tag, "_latency"}, 64'(lat), 64'(e.lat));
            checkOutput({tag, "_hi"}, {32'b0, hi}, {32'b0, e.hi});
            checkOutput({tag, "_lo"}, {32'b0, lo}, {32'b0, e.lo});
            checkOutput({tag, "_divzero"}, {63'b0, div_zero}, {63'b0, e.dz});
            checkOutput({tag, "_busy_off"}, {63'b0, busy}, 64'd0);
            checkOutput({tag, "_hilo_stable"}, {63'b0, stableOk}, 64'd1);
            checkOutput({tag, "_busy_held"}, {63'b0, busyOk}, 64'd1);
            mHi = e.hi;
            mLo = e.lo;
        end
        tick();
        checkOutput({tag, "_pulse"}, {63'b0, done}, 64'd0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op    = 3'b000;
        opA   = '0;
        opB   = '0;
        #12;
        checkOutput("rst_busy", {63'b0, busy}, 64'd0);
        checkOutput("rst_done", {63'b0, done}, 64'd0);
        checkOutput("rst_divzero", {63'b0, div_zero}, 64'd0);
        checkOutput("rst_hi", {32'b0, hi}, 64'd0);
        checkOutput("rst_lo", {32'b0, lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] MULTU max operands");
        applyStimulus("multu_max", 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF);
        awaitResult("multu_max");

        $display("[TB] signed multiply and divide");
        applyStimulus("mult_neg", 3'b001, 32'hFFFFFFFE, 32'd3);
        awaitResult("mult_neg");
        applyStimulus("div_neg", 3'b011, 32'hFFFFFFF9, 32'd2);
        awaitResult("div_neg");
        applyStimulus("divu_basic", 3'b010, 32'd1000, 32'd7);
        awaitResult("divu_basic");
        applyStimulus("div_negdivisor", 3'b011, 32'd7, 32'hFFFFFFFE);
        awaitResult("div_negdivisor");

        $display("[TB] divide by zero and overflow");
        applyStimulus("divu_zero", 3'b010, 32'd100, 32'd0);
        awaitResult("divu_zero");
        applyStimulus("div_ovf", 3'b011, 32'h80000000, 32'hFFFFFFFF);
        awaitResult("div_ovf");

        $display("[TB] start while busy");
        applyStimulus("mthi", 3'b100, 32'h12345678, 32'd0);
        d0 = doneCount;
        applyStimulus("busy_multu", 3'b000, 32'd3, 32'd5);
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        @(negedge clk);
        start = 1'b1;
        op    = 3'b000;
        opA   = 32'd9;
        opB   = 32'd9;
        tick();
        start = 1'b0;
        awaitResult("busy_multu");
        for (int i = 0; i < 40; i++) begin
            tick();
        end
        checkOutput("busy_single_done", 64'(doneCount - d0), 64'd1);
        checkOutput("busy_no_rerun", {63'b0, busy}, 64'd0);

        $display("[TB] reset mid-run");
        d0 = doneCount;
        applyStimulus("rst_multu", 3'b000, 32'h0000DEAD, 32'h0000BEEF);
        for (int i = 0; i < 9; i++) begin
            tick();
        end
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_busy", {63'b0, busy}, 64'd0);
        checkOutput("midrst_hi", {32'b0, hi}, 64'd0);
        checkOutput("midrst_lo", {32'b0, lo}, 64'd0);
        checkOutput("midrst_done", {63'b0, done}, 64'd0);
        mHi = '0;
        mLo = '0;
        dropped = sb.pop_front();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
        end
        checkOutput("midrst_no_done", 64'(doneCount - d0), 64'd0);
        applyStimulus("after_rst", 3'b000, 32'd6, 32'd7);
        awaitResult("after_rst");

`ifdef MULDIV_MADD_EN
        $display("[TB] multiply-accumulate");
        applyStimulus("mtlo", 3'b101, 32'hFFFFFFFF, 32'd0);
        applyStimulus("mthi0", 3'b100, 32'd0, 32'd0);
        applyStimulus("maddu", 3'b110, 32'd1, 32'd1);
        awaitResult("maddu");
        applyStimulus("madd_neg", 3'b111, 32'hFFFFFFFF, 32'd1);
        awaitResult("madd_neg");
`else
        $display("[TB] illegal accumulate op");
        d0       = doneCount;
        stableOk = 1'b1;
        @(negedge clk);
        start = 1'b1;
        op    = 3'b111;
        opA   = 32'd5;
        opB   = 32'd5;
        tick();
        start = 1'b0;
        checkOutput("illegal_busy", {63'b0, busy}, 64'd0);
        for (int i = 0; i < 40; i++) begin
            tick();
        end
        checkOutput("illegal_no_done", 64'(doneCount - d0), 64'd0);
        checkOutput("illegal_hilo_stable", {63'b0, stableOk}, 64'd1);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
